// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage.
// Holds one EX/MEM bundle, performs at most one load/store on a ready/ack
// data-memory port, stalls upstream until the access completes and then
// emits a one-cycle-valid MEM/WB bundle.
// Optional feature macro: MEMSTAGE_ALIGN_CHECK_EN (misaligned-access trap
// with sticky AlignErr flag). Undefined by default.
module memory_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        InValid,
  output logic        InReady,
  input  logic        RegWriteIn,
  input  logic        MemToRegIn,
  input  logic        MemWriteIn,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] WriteDataIn,
  input  logic [4:0]  WriteRegIn,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  input  logic        DMemAck,
  input  logic [31:0] DMemRData,
  output logic        OutValid,
  output logic        RegWriteOut,
  output logic        MemToRegOut,
  output logic [31:0] ALUResultOut,
  output logic [31:0] ReadDataOut,
  output logic [4:0]  WriteRegOut,
  output logic        AlignErr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PASS   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  // EX/MEM slot fields
  logic        slot_reg_write;
  logic        slot_mem_to_reg;
  logic        slot_mem_write;
  logic        slot_misaligned;
  logic [31:0] slot_alu;
  logic [31:0] slot_wdata;
  logic [4:0]  slot_wreg;

  logic        pending;
  logic        in_access;
  logic        xfer;
  logic        accept;
  logic        in_is_mem;
  logic        in_misaligned;
  logic        in_goes_access;

  // Incoming bundle classification
  assign in_is_mem = MemWriteIn | MemToRegIn;

`ifdef MEMSTAGE_ALIGN_CHECK_EN
  assign in_misaligned = in_is_mem & (ALUResultIn[1:0] != 2'b00);
`else
  assign in_misaligned = 1'b0;
`endif

  // A misaligned memory op is diverted through PASS timing and never
  // touches the memory port.
  assign in_goes_access = in_is_mem & ~in_misaligned;

  // Handshake: the slot frees up in the same cycle its contents transfer,
  // so DMemAck reaches InReady combinationally for zero-bubble operation.
  assign pending   = (state != ST_IDLE);
  assign in_access = (state == ST_ACCESS);
  assign xfer      = (state == ST_PASS) | (in_access & DMemAck);
  assign InReady   = ~pending | xfer;
  assign accept    = InValid & InReady;

  // Memory port driven straight from the slot so it is stable for the
  // whole request; the write-enable is gated so it is only 1 during ACCESS.
  assign DMemReq   = in_access;
  assign DMemWe    = in_access & slot_mem_write;
  assign DMemAddr  = {slot_alu[31:2], 2'b00};
  assign DMemWData = slot_wdata;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: a new accept always wins; otherwise a transfer empties
  // the slot; otherwise hold.
  always_comb begin
    state_next = state;
    if (accept) begin
      if (in_goes_access) begin
        state_next = ST_ACCESS;
      end else begin
        state_next = ST_PASS;
      end
    end else if (xfer) begin
      state_next = ST_IDLE;
    end else begin
      state_next = state;
    end
  end

  // EX/MEM slot capture on accept; a store that also claims MemToReg keeps
  // MemToReg cleared so write-back never selects load data for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_reg_write  <= 1'b0;
      slot_mem_to_reg <= 1'b0;
      slot_mem_write  <= 1'b0;
      slot_misaligned <= 1'b0;
      slot_alu        <= 32'd0;
      slot_wdata      <= 32'd0;
      slot_wreg       <= 5'd0;
    end else if (accept) begin
      slot_reg_write  <= RegWriteIn;
      slot_mem_to_reg <= MemToRegIn & ~MemWriteIn;
      slot_mem_write  <= MemWriteIn;
      slot_misaligned <= in_misaligned;
      slot_alu        <= ALUResultIn;
      slot_wdata      <= WriteDataIn;
      slot_wreg       <= WriteRegIn;
    end else begin
      slot_reg_write  <= slot_reg_write;
      slot_mem_to_reg <= slot_mem_to_reg;
      slot_mem_write  <= slot_mem_write;
      slot_misaligned <= slot_misaligned;
      slot_alu        <= slot_alu;
      slot_wdata      <= slot_wdata;
      slot_wreg       <= slot_wreg;
    end
  end

  // MEM/WB register: one-cycle valid pulse per transfer, data held between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OutValid     <= 1'b0;
      RegWriteOut  <= 1'b0;
      MemToRegOut  <= 1'b0;
      ALUResultOut <= 32'd0;
      ReadDataOut  <= 32'd0;
      WriteRegOut  <= 5'd0;
    end else begin
      OutValid <= xfer;
      if (xfer) begin
        RegWriteOut  <= slot_reg_write & ~slot_misaligned;
        MemToRegOut  <= slot_mem_to_reg;
        ALUResultOut <= slot_alu;
        WriteRegOut  <= slot_wreg;
        if (in_access && !slot_mem_write) begin
          ReadDataOut <= DMemRData;
        end else begin
          ReadDataOut <= 32'd0;
        end
      end else begin
        RegWriteOut  <= RegWriteOut;
        MemToRegOut  <= MemToRegOut;
        ALUResultOut <= ALUResultOut;
        WriteRegOut  <= WriteRegOut;
        ReadDataOut  <= ReadDataOut;
      end
    end
  end

`ifdef MEMSTAGE_ALIGN_CHECK_EN
  // Sticky misalignment flag, set when a trapped op transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AlignErr <= 1'b0;
    end else if (xfer && slot_misaligned) begin
      AlignErr <= 1'b1;
    end else begin
      AlignErr <= AlignErr;
    end
  end
`else
  assign AlignErr = 1'b0;
`endif

endmodule
